// File: rtl/mss_sys_clk_gen_pkg.sv
// Shared constants, channel state encoding and width helper for the
// multi-channel clock-enable generator.
package mss_sys_clk_gen_pkg;

  localparam int NUM_CH_DEF   = 4;
  localparam int DIV_W_DEF    = 8;
  localparam int LOCK_CNT_DEF = 16;
  localparam int DIV_INIT_DEF = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  // Ceiling log2, never below 1 so single-entry selects still get a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mss_sys_clk_gen_ch.sv
// One divider channel: period counter, pending-divisor register, IDLE/RUN
// state and registered CE / DIV_OUT / WR_ACK outputs.
module mss_sys_clk_gen_ch
  import mss_sys_clk_gen_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             lock_i,
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             ce_o,
  output logic             div_out_o,
  output logic             wr_ack_o
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             ce_q, ce_d;
  logic             div_out_q, div_out_d;
  logic             ack_q, ack_d;
  logic             wrap;
  logic             apply;

  // Outputs are computed from the next counter/state so that the registered
  // CE and DIV_OUT describe the cycle the counter value belongs to.
  always_comb begin
    wrap  = (state_q == RUN) && (cnt_q == div_q - DIV_W'(1));
    apply = pend_q && ((state_q == IDLE) || wrap);
    div_d = apply ? pend_div_q : div_q;

    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    if (wr_en_i) begin
      pend_d     = 1'b1;
      pend_div_d = wr_div_i;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    if (!lock_i || (div_d == '0)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if ((state_q == IDLE) || wrap) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      state_d = RUN;
      cnt_d   = cnt_q + DIV_W'(1);
    end

    ce_d      = (state_d == RUN) && (cnt_d == div_d - DIV_W'(1));
    div_out_d = (state_d == RUN) && (cnt_d < (div_d >> 1));
    ack_d     = apply;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(DIV_INIT);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      ce_q       <= 1'b0;
      div_out_q  <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      ce_q       <= ce_d;
      div_out_q  <= div_out_d;
      ack_q      <= ack_d;
    end
  end

  assign ce_o      = ce_q;
  assign div_out_o = div_out_q;
  assign wr_ack_o  = ack_q;

endmodule

// File: rtl/mss_sys_clk_gen.sv
// Clock-enable generator top: PLL lock synchroniser and debounce filter,
// divisor write decode, and NUM_CH divider channels.
module mss_sys_clk_gen
  import mss_sys_clk_gen_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DIV_W    = DIV_W_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic                     CLK,
  input  logic                     ARST_N,
  input  logic                     PLL_LOCK,
  input  logic                     WR_EN,
  input  logic [clog2(NUM_CH)-1:0] WR_CH,
  input  logic [DIV_W-1:0]         WR_DIV,
  output logic                     WR_ERR,
  output logic [NUM_CH-1:0]        WR_ACK,
  output logic                     LOCK_STABLE,
  output logic [NUM_CH-1:0]        CE,
  output logic [NUM_CH-1:0]        DIV_OUT
);

  localparam int                CH_W     = clog2(NUM_CH);
  localparam int                LCNT_W   = clog2(LOCK_CNT);
  localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_CNT - 1);
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic              sync1_q, sync2_q;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              stable_q, stable_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_valid;
  logic [NUM_CH-1:0] wr_hit;

  always_comb begin
    lcnt_d   = lcnt_q;
    stable_d = stable_q;
    if (!sync2_q) begin
      lcnt_d   = '0;
      stable_d = 1'b0;
    end else if (lcnt_q == LCNT_MAX) begin
      stable_d = 1'b1;
    end else begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end

    wr_valid = ({1'b0, WR_CH} < CH_LIMIT);
    wr_err_d = WR_EN && !wr_valid;
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      lcnt_q   <= '0;
      stable_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      sync1_q  <= PLL_LOCK;
      sync2_q  <= sync1_q;
      lcnt_q   <= lcnt_d;
      stable_q <= stable_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Channels follow the next lock value so they leave IDLE on the same edge
  // LOCK_STABLE rises and drop their outputs on the edge it falls.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_hit[gi] = WR_EN && wr_valid && (WR_CH == CH_W'(gi));

    mss_sys_clk_gen_ch #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_ch (
      .clk       (CLK),
      .arst_n    (ARST_N),
      .lock_i    (stable_d),
      .wr_en_i   (wr_hit[gi]),
      .wr_div_i  (WR_DIV),
      .ce_o      (CE[gi]),
      .div_out_o (DIV_OUT[gi]),
      .wr_ack_o  (WR_ACK[gi])
    );
  end

  assign LOCK_STABLE = stable_q;
  assign WR_ERR      = wr_err_q;

endmodule
